// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_STEP       = 4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives imem requests and a one-entry decode buffer.
// Optional redirect counter output enabled by defining FETCH_REDIRECT_CNT_EN.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned    AW        = 32,
  parameter int unsigned    IW        = 32,
  parameter logic [AW-1:0]  RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          if_valid,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          id_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_target
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0]   redirect_cnt
`endif
);

  fetch_state_t  r_state, w_state_next;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [AW-1:0] r_drain_addr, w_drain_addr_next;
  logic          r_if_valid, w_if_valid_next;
  logic [IW-1:0] r_if_instr, w_if_instr_next;
  logic [AW-1:0] r_if_pc, w_if_pc_next;
  logic          w_imem_req;
  logic [AW-1:0] w_imem_addr;
  logic [AW-1:0] w_target_aligned;
  logic [AW-1:0] w_pc_inc;

  assign w_target_aligned = redirect_target & ~AW'(PC_ALIGN_MASK);
  assign w_pc_inc         = r_pc + AW'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VEC;
      r_drain_addr <= RESET_VEC;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_drain_addr <= w_drain_addr_next;
      r_if_valid   <= w_if_valid_next;
      r_if_instr   <= w_if_instr_next;
      r_if_pc      <= w_if_pc_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_drain_addr_next = r_drain_addr;
    w_if_valid_next   = r_if_valid;
    w_if_instr_next   = r_if_instr;
    w_if_pc_next      = r_if_pc;
    w_imem_req        = 1'b0;
    w_imem_addr       = r_pc;

    unique case (r_state)
      BOOT: begin
        w_state_next = REQ;
      end
      REQ: begin
        w_imem_req = 1'b1;
        if (redirect) begin
          w_pc_next         = w_target_aligned;
          w_if_valid_next   = 1'b0;
          w_drain_addr_next = r_pc;
          w_state_next      = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          w_if_instr_next = imem_rdata;
          w_if_pc_next    = r_pc;
          w_if_valid_next = 1'b1;
          w_pc_next       = w_pc_inc;
          w_state_next    = FULL;
        end
      end
      FULL: begin
        if (redirect) begin
          w_pc_next       = w_target_aligned;
          w_if_valid_next = 1'b0;
          w_state_next    = REQ;
        end else if (id_ready) begin
          w_if_valid_next = 1'b0;
          w_state_next    = REQ;
        end
      end
      DRAIN: begin
        // The abandoned request stays on the bus until acked; a later redirect only
        // replaces the pending target so the address never moves under req.
        w_imem_req  = 1'b1;
        w_imem_addr = r_drain_addr;
        if (redirect) begin
          w_pc_next = w_target_aligned;
        end
        if (imem_ack) begin
          w_state_next = REQ;
        end
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  assign imem_req  = w_imem_req;
  assign imem_addr = w_imem_addr;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] r_redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_cnt <= '0;
    end else if (redirect && (r_state != BOOT) && (r_redirect_cnt != 16'hFFFF)) begin
      r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: per-cycle reference model plus hand-computed anchors.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, if_valid, id_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, redirect_target;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, instr2, pc2;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt, redirect_cnt2;
`endif

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect       (redirect),
    .redirect_target(redirect_target)
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    .redirect_cnt   (redirect_cnt)
`endif
  );

  // Second instance exercises PC wrap from a high reset vector; zero-latency memory.
  assign ack2 = req2;
  fetch_pc_ctrl #(.RESET_VEC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_ack       (ack2),
    .imem_rdata     (32'h0),
    .if_valid       (valid2),
    .if_instr       (instr2),
    .if_pc          (pc2),
    .id_ready       (1'b1),
    .redirect       (1'b0),
    .redirect_target(32'h0)
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    .redirect_cnt   (redirect_cnt2)
`endif
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "waiting for fetch" whenever out of boot with an empty buffer.
  logic        m_boot, m_buf_v, m_drain;
  logic [31:0] m_buf_i, m_buf_pc, m_pc, m_hold;
  int          m_cnt;
  logic        e_req;
  logic [31:0] e_addr;
  assign e_req  = !m_boot && !m_buf_v;
  assign e_addr = m_drain ? m_hold : m_pc;

  always @(posedge clk) begin
    if (rst) begin
      m_boot   <= 1'b1;
      m_buf_v  <= 1'b0;
      m_buf_i  <= '0;
      m_buf_pc <= '0;
      m_pc     <= 32'h0;
      m_hold   <= 32'h0;
      m_drain  <= 1'b0;
      m_cnt    <= 0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (redirect) begin
      if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (e_req && !imem_ack) begin
        m_hold  <= e_addr;
        m_drain <= 1'b1;
      end else begin
        m_drain <= 1'b0;
      end
      m_buf_v <= 1'b0;
      m_pc    <= redirect_target & ~32'h3;
    end else if (e_req && imem_ack) begin
      if (m_drain) begin
        m_drain <= 1'b0;
      end else begin
        m_buf_v  <= 1'b1;
        m_buf_i  <= mem_word(e_addr);
        m_buf_pc <= e_addr;
        m_pc     <= e_addr + 32'd4;
      end
    end else if (m_buf_v && id_ready) begin
      m_buf_v <= 1'b0;
    end
  end

  bit          chk_en = 1'b0;
  bit          rec_en = 1'b0;
  logic [31:0] fq[$];
  logic [31:0] fq2[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk("imem_addr", imem_addr, e_addr);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_buf_v});
      if (m_buf_v) begin
        chk("if_instr", if_instr, m_buf_i);
        chk("if_pc", if_pc, m_buf_pc);
      end
`ifdef FETCH_REDIRECT_CNT_EN
      chk("redirect_cnt", {16'b0, redirect_cnt}, m_cnt[31:0]);
`endif
    end
    if (rec_en && imem_req && imem_ack) fq.push_back(imem_addr);
    if (!rst && req2 && fq2.size() < 3) fq2.push_back(addr2);
  end

  int ack_delay = 1;
  int wcnt      = 0;
  bit force_ack = 1'b0;

  // Advance one cycle, then play the memory for the new cycle.
  task automatic step();
    @(posedge clk);
    #2;
    redirect = 1'b0;
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else if (imem_req) begin
      if (wcnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  endtask

  task automatic wait_req(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = imem_req;
    end
    chk(name, {31'b0, found}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit found = if_valid;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = if_valid;
    end
    chk(name, {31'b0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst             = 1'b1;
    id_ready        = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    step();
    step();
    chk_en = 1'b1;
    step();
    chk("reset imem_req", {31'b0, imem_req}, 32'd0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset if_valid", {31'b0, if_valid}, 32'd0);
    chk("reset if_instr", if_instr, 32'h0);
    chk("reset if_pc", if_pc, 32'h0);

    // Sequential fetch, ack one cycle after request.
    rst    = 1'b0;
    rec_en = 1'b1;
    repeat (12) step();
    rec_en = 1'b0;
    chk("fetch count", {31'b0, fq.size() >= 3}, 32'd1);
    if (fq.size() >= 3) begin
      chk("fetch0 addr", fq[0], 32'h0);
      chk("fetch1 addr", fq[1], 32'h4);
      chk("fetch2 addr", fq[2], 32'h8);
    end

    // Decode stall: buffer must hold and no request may issue.
    id_ready = 1'b0;
    wait_valid("stall wait valid");
    repeat (5) step();
    chk("stall if_valid", {31'b0, if_valid}, 32'd1);
    chk("stall imem_req", {31'b0, imem_req}, 32'd0);
    chk("stall if_pc", if_pc, 32'hC);

    // Redirect during a slow request: drain the old one, then fetch the target.
    id_ready  = 1'b1;
    ack_delay = 3;
    wait_req("drain wait req");
    redirect        = 1'b1;
    redirect_target = 32'h100;
    step();
    chk("drain old addr", imem_addr, 32'h10);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = imem_req && (imem_addr == 32'h100);
    end
    chk("drain reach target", {31'b0, found}, 32'd1);
    chk("drain if_valid", {31'b0, if_valid}, 32'd0);
    ack_delay = 1;
    wait_valid("target wait valid");
    chk("target if_pc", if_pc, 32'h100);
    chk("target if_instr", if_instr, mem_word(32'h100));

    // Redirect coinciding with ack and id_ready: word dropped, target aligned.
    ack_delay = 0;
    found     = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = imem_req && imem_ack;
    end
    chk("ack wait", {31'b0, found}, 32'd1);
    redirect        = 1'b1;
    redirect_target = 32'h203;
    step();
    chk("aligned addr", imem_addr, 32'h200);
    chk("aligned req", {31'b0, imem_req}, 32'd1);
    chk("flush if_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("aligned if_pc", if_pc, 32'h200);

    // Reset while draining, with ack arriving during reset.
    ack_delay = 3;
    wait_req("rst wait req");
    redirect        = 1'b1;
    redirect_target = 32'h40;
    step();
    chk("rst drain addr", imem_addr, 32'h204);
`ifdef FETCH_REDIRECT_CNT_EN
    chk("cnt three", {16'b0, redirect_cnt}, 32'd3);
`endif
    rst       = 1'b1;
    force_ack = 1'b1;
    step();
    chk("rst imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst if_valid", {31'b0, if_valid}, 32'd0);
    step();
    rst       = 1'b0;
    force_ack = 1'b0;
    ack_delay = 1;
    wait_req("post rst req");
    chk("post rst addr", imem_addr, 32'h0);
    chk("post rst if_valid", {31'b0, if_valid}, 32'd0);
    repeat (6) step();

    chk("wrap count", {31'b0, fq2.size() == 3}, 32'd1);
    if (fq2.size() == 3) begin
      chk("wrap addr0", fq2[0], 32'hFFFF_FFF8);
      chk("wrap addr1", fq2[1], 32'hFFFF_FFFC);
      chk("wrap addr2", fq2[2], 32'h0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
